// File: rtl/spike_synapse_decoder.sv
// Spike-to-current synapse: edge-triggered weighted kicks into a decaying 8.8 accumulator,
// plus a windowed firing-rate counter with valid/ready output. Optional macro: SYN_REFRACTORY_EN.
module spike_synapse_decoder #(
    parameter int unsigned DECAY_SHIFT = 3,
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned REFRACT     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spike_in,
    input  logic       tick,
    input  logic [7:0] weight,
    output logic [7:0] current_out,
    output logic [7:0] rate_count,
    output logic       rate_valid,
    input  logic       rate_ready,
    output logic       overrun
);

    localparam int unsigned SYN_W  = 16;
    localparam int unsigned WCNT_W = 16;
    localparam int unsigned RATE_W = 8;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

    logic              spike_d;
    logic              rise;
    logic              accepted;
    logic [SYN_W-1:0]  syn;
    logic [SYN_W-1:0]  decay;
    logic [SYN_W:0]    syn_sum;
    logic [WCNT_W-1:0] wcnt;
    logic [RATE_W-1:0] scnt;
    logic [RATE_W:0]   scnt_inc;
    logic [RATE_W-1:0] scnt_sat;
    logic              window_close;

    // Rising-edge detector on the spike level
    always_ff @(posedge clock) begin
        if (reset) spike_d <= 1'b0;
        else       spike_d <= spike_in;
    end

    assign rise = spike_in & ~spike_d;

`ifdef SYN_REFRACTORY_EN
    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_REFRACTORY = 1'b1;
    localparam logic [7:0] RCNT_LOAD     = 8'(REFRACT - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] rcnt;
    logic [7:0] rcnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            rcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Accept one rise, then ignore rises until the refractory count has run out
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        accepted  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    accepted = 1'b1;
                    if (REFRACT > 1) begin
                        state_nxt = ST_REFRACTORY;
                        rcnt_nxt  = RCNT_LOAD;
                    end
                end
            end
            ST_REFRACTORY: begin
                if (rcnt == 8'd0) state_nxt = ST_IDLE;
                else              rcnt_nxt  = rcnt - 8'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
`else
    assign accepted = rise;
`endif

    // Decay has a floor of 1 so the accumulator always drains to exactly zero
    always_comb begin
        decay = '0;
        if (tick) begin
            decay = syn >> DECAY_SHIFT;
            if (decay == '0 && syn != '0) decay = SYN_W'(1);
        end
        syn_sum = {1'b0, syn} - {1'b0, decay}
                + (accepted ? {1'b0, weight, 8'h00} : (SYN_W + 1)'(0));
    end

    always_ff @(posedge clock) begin
        if (reset)           syn <= '0;
        else if (syn_sum[SYN_W]) syn <= '1;
        else                 syn <= syn_sum[SYN_W-1:0];
    end

    assign current_out = syn[15:8];

    assign window_close = tick && (wcnt == WCNT_LAST);
    assign scnt_inc     = {1'b0, scnt} + (RATE_W + 1)'(accepted);
    assign scnt_sat     = scnt_inc[RATE_W] ? '1 : scnt_inc[RATE_W-1:0];

    // Rate window; an edge on the closing tick lands in the reported result
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt       <= '0;
            scnt       <= '0;
            rate_count <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (tick) wcnt <= window_close ? '0 : wcnt + WCNT_W'(1);
            scnt <= window_close ? '0 : scnt_sat;
            if (window_close) rate_count <= scnt_sat;
            if (window_close)    rate_valid <= 1'b1;
            else if (rate_ready) rate_valid <= 1'b0;
            if (window_close && rate_valid && !rate_ready) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spike_synapse_decoder.sv
// Directed bench for spike_synapse_decoder with a queue scoreboard on the rate handshake.
module tb_spike_synapse_decoder;

`ifdef SYN_REFRACTORY_EN
    localparam bit REF_ON = 1'b1;
`else
    localparam bit REF_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       spike_in;
    logic       tick;
    logic [7:0] weight;
    logic [7:0] current_out;
    logic [7:0] rate_count;
    logic       rate_valid;
    logic       rate_ready;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int mon_exp;
    logic [15:0] pat;

    spike_synapse_decoder #(
        .DECAY_SHIFT(3),
        .WINDOW     (16),
        .REFRACT    (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .spike_in   (spike_in),
        .tick       (tick),
        .weight     (weight),
        .current_out(current_out),
        .rate_count (rate_count),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        spike_in   = 1'b0;
        tick       = 1'b0;
        rate_ready = 1'b0;
        weight     = 8'h00;
        cyc(2);
        reset = 1'b0;
    endtask

    // One 16-tick window with a tick every third cycle and nspk rises six cycles apart
    task automatic run_window(input int nspk);
        for (int c = 0; c < 48; c++) begin
            spike_in = (c % 6 == 0) && (c / 6 < nspk);
            tick     = (c % 3 == 2);
            cyc(1);
        end
        spike_in = 1'b0;
        tick     = 1'b0;
    endtask

    // Scoreboard monitor: every handshake transfer consumes one expected result
    always @(negedge clock) begin
        if (!reset && rate_valid && rate_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rate_xfer: got unexpected result 0x%0h, expected none", rate_count);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(rate_count) != mon_exp) begin
                    n_bad++;
                    $display("FAIL rate_xfer: got 0x%0h, expected 0x%0h at %0t", rate_count, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        // Reset held with spike high; the first cycle after release counts as a rise
        reset      = 1'b1;
        spike_in   = 1'b1;
        weight     = 8'h40;
        tick       = 1'b0;
        rate_ready = 1'b0;
        cyc(3);
        chk("reset_current", int'(current_out), 0);
        chk("reset_rate_count", int'(rate_count), 0);
        chk("reset_rate_valid", int'(rate_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        cyc(1);
        chk("first_rise_current", int'(current_out), 8'h40);

        // Decay from 0x4000
        tick = 1'b1;
        cyc(1);
        chk("decay_one_tick", int'(current_out), 8'h38);
        cyc(150);
        chk("decay_drained", int'(current_out), 0);
        cyc(20);
        chk("decay_stays_zero", int'(current_out), 0);

        // Saturation
        do_reset();
        weight = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            spike_in = 1'b1;
            cyc(1);
            chk("sat_kick", int'(current_out), 8'hFF);
            spike_in = 1'b0;
            cyc(5);
        end
        spike_in = 1'b1;
        tick     = 1'b1;
        cyc(1);
        chk("sat_tick_plus_edge", int'(current_out), 8'hFF);
        spike_in = 1'b0;
        cyc(1);
        chk("sat_then_decay", int'(current_out), 8'hE0);
        tick = 1'b0;

        // Refractory spacing
        do_reset();
        weight   = 8'h10;
        spike_in = 1'b1;
        cyc(1);
        chk("refr_first", int'(current_out), 8'h10);
        spike_in = 1'b0;
        cyc(1);
        spike_in = 1'b1;
        cyc(1);
        chk("refr_gap2", int'(current_out), REF_ON ? 8'h10 : 8'h20);
        spike_in = 1'b0;
        cyc(6);
        spike_in = 1'b1;
        cyc(1);
        chk("refr_after_idle", int'(current_out), REF_ON ? 8'h20 : 8'h30);
        spike_in = 1'b0;
        cyc(4);
        spike_in = 1'b1;
        cyc(1);
        chk("refr_gap5", int'(current_out), REF_ON ? 8'h30 : 8'h40);
        spike_in = 1'b0;
        cyc(3);
        spike_in = 1'b1;
        cyc(1);
        chk("refr_gap4", int'(current_out), REF_ON ? 8'h30 : 8'h50);
        spike_in = 1'b0;
        cyc(1);
        spike_in = 1'b1;
        cyc(1);
        chk("refr_gap2_after_ignored", int'(current_out), REF_ON ? 8'h40 : 8'h60);
        spike_in = 1'b0;

        // Rate window of 16 ticks, rises at ticks 1,3,6,9,11 and the closing tick 16
        do_reset();
        tick = 1'b1;
        pat  = 16'b1000_0101_0010_0101;
        for (int j = 0; j < 15; j++) begin
            spike_in = pat[j];
            cyc(1);
        end
        chk("rate_not_yet_valid", int'(rate_valid), 0);
        spike_in = pat[15];
        cyc(1);
        spike_in = 1'b0;
        chk("rate_valid_after_close", int'(rate_valid), 1);
        chk("rate_count_closing_edge", int'(rate_count), REF_ON ? 4 : 6);
        exp_q.push_back(REF_ON ? 4 : 6);
        rate_ready = 1'b1;
        cyc(1);
        chk("rate_valid_cleared", int'(rate_valid), 0);
        chk("rate_no_overrun", int'(overrun), 0);
        rate_ready = 1'b0;
        tick       = 1'b0;

        // Overrun across two unconsumed windows, then a back-to-back consume
        do_reset();
        run_window(3);
        chk("ovr_win1_valid", int'(rate_valid), 1);
        chk("ovr_win1_count", int'(rate_count), 3);
        chk("ovr_win1_flag", int'(overrun), 0);
        run_window(7);
        chk("ovr_win2_count", int'(rate_count), 7);
        chk("ovr_win2_valid", int'(rate_valid), 1);
        chk("ovr_win2_flag", int'(overrun), 1);
        exp_q.push_back(7);
        rate_ready = 1'b1;
        cyc(1);
        chk("ovr_consumed_valid", int'(rate_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        exp_q.push_back(2);
        run_window(2);
        chk("b2b_result_valid", int'(rate_valid), 1);
        chk("b2b_result_count", int'(rate_count), 2);
        cyc(1);
        chk("b2b_consumed", int'(rate_valid), 0);
        chk("b2b_overrun_sticky", int'(overrun), 1);
        do_reset();
        chk("ovr_cleared_by_reset", int'(overrun), 0);
        chk("post_reset_valid", int'(rate_valid), 0);
        chk("post_reset_count", int'(rate_count), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
